// File: rtl/pc_exception_ctrl.sv
// pc_exception_ctrl: exception-entry / exception-return sequencer that sits in
// front of the PC source mux and PC write enable of the multicycle CPU.
// In IDLE the main control unit's PC select/write pass straight through; on an
// exception EPC and cause are saved, the handler byte is fetched from memory
// and loaded into the PC via mux input 3; on eret the PC is restored from EPC.
module pc_exception_ctrl #(
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ctrl_pcsource,
    input  logic        ctrl_pcwrite,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    input  logic        eret,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_rdata,
    output logic [1:0]  muxpcsource,
    output logic        pc_write,
    output logic [31:0] pc_src3,
    output logic [31:0] epc_out,
    output logic [1:0]  cause,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic        exc_busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MEMRD = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_RET   = 3'd4
    } state_e;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_OPCODE = 2'd1;
    localparam logic [1:0] CAUSE_OVF    = 2'd2;
    localparam logic [1:0] CAUSE_DIV0   = 2'd3;

    // Fixed-priority winner among simultaneous events: opcode > ovf > div0.
    function automatic logic [1:0] exc_winner(input logic op_i, input logic ovf_i,
                                              input logic div0_i);
        logic [1:0] w;
        if (op_i) begin
            w = CAUSE_OPCODE;
        end else if (ovf_i) begin
            w = CAUSE_OVF;
        end else if (div0_i) begin
            w = CAUSE_DIV0;
        end else begin
            w = CAUSE_NONE;
        end
        return w;
    endfunction

    // Memory byte address of the handler vector for a given cause.
    function automatic logic [31:0] vec_addr(input logic [1:0] c);
        logic [31:0] a;
        case (c)
            CAUSE_OPCODE: a = VEC_OPCODE;
            CAUSE_OVF:    a = VEC_OVF;
            CAUSE_DIV0:   a = VEC_DIV0;
            default:      a = 32'd0;
        endcase
        return a;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] vec_q, vec_d;
    logic [1:0]  cause_q, cause_d;
    logic        exc_any_s;

    assign exc_any_s = exc_opcode | exc_ovf | exc_div0;

    // State and architectural registers; async reset aborts any sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            epc_q   <= 32'd0;
            vec_q   <= 32'd0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            vec_q   <= vec_d;
            cause_q <= cause_d;
        end
    end

    // Next-state and register-update logic; events outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        vec_d   = vec_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_any_s) begin
                    // EPC points back at the faulting instruction (wraps mod 2^32).
                    epc_d   = pc_in - 32'd4;
                    cause_d = exc_winner(exc_opcode, exc_ovf, exc_div0);
                    state_d = ST_MEMRD;
                end else if (eret) begin
                    state_d = ST_RET;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEMRD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data is valid the cycle after the strobe.
                vec_d   = {24'd0, mem_rdata};
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            ST_RET: begin
                cause_d = CAUSE_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; everything forced to zero while reset is asserted.
    always_comb begin
        muxpcsource = 2'd0;
        pc_write    = 1'b0;
        pc_src3     = epc_q;
        epc_out     = epc_q;
        cause       = cause_q;
        mem_rd      = 1'b0;
        mem_addr    = 32'd0;
        exc_busy    = 1'b1;
        if (!rst_n) begin
            pc_src3  = 32'd0;
            epc_out  = 32'd0;
            cause    = CAUSE_NONE;
            exc_busy = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    muxpcsource = ctrl_pcsource;
                    pc_write    = ctrl_pcwrite;
                    exc_busy    = 1'b0;
                end
                ST_MEMRD: begin
                    mem_rd   = 1'b1;
                    mem_addr = vec_addr(cause_q);
                end
                ST_WAIT: begin
                    mem_rd = 1'b0;
                end
                ST_LOAD: begin
                    muxpcsource = 2'd3;
                    pc_src3     = vec_q;
                    pc_write    = 1'b1;
                end
                ST_RET: begin
                    muxpcsource = 2'd3;
                    pc_src3     = epc_q;
                    pc_write    = 1'b1;
                end
                default: begin
                    exc_busy = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_exception_ctrl.sv
// Directed, table-driven bench for pc_exception_ctrl with hand-computed
// expectations, plus hand-written reset sequences.
module tb_pc_exception_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ctrl_pcsource;
    logic        ctrl_pcwrite;
    logic        exc_opcode;
    logic        exc_ovf;
    logic        exc_div0;
    logic        eret;
    logic [31:0] pc_in;
    logic [7:0]  mem_rdata;
    logic [1:0]  muxpcsource;
    logic        pc_write;
    logic [31:0] pc_src3;
    logic [31:0] epc_out;
    logic [1:0]  cause;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        exc_busy;

    int checks = 0;
    int failures = 0;

    pc_exception_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ctrl_pcsource (ctrl_pcsource),
        .ctrl_pcwrite  (ctrl_pcwrite),
        .exc_opcode    (exc_opcode),
        .exc_ovf       (exc_ovf),
        .exc_div0      (exc_div0),
        .eret          (eret),
        .pc_in         (pc_in),
        .mem_rdata     (mem_rdata),
        .muxpcsource   (muxpcsource),
        .pc_write      (pc_write),
        .pc_src3       (pc_src3),
        .epc_out       (epc_out),
        .cause         (cause),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .exc_busy      (exc_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  pcsrc;
        logic        pcw;
        logic        eop;
        logic        eovf;
        logic        ediv;
        logic        eret;
        logic [31:0] pcin;
        logic [7:0]  rdata;
        logic [1:0]  x_mux;
        logic        x_pw;
        logic [31:0] x_src3;
        logic [31:0] x_epc;
        logic [1:0]  x_cause;
        logic        x_rd;
        logic [31:0] x_addr;
        logic        x_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mux"},   {30'd0, muxpcsource}, 32'd0);
        check({tag, "_pw"},    {31'd0, pc_write},    32'd0);
        check({tag, "_src3"},  pc_src3,              32'd0);
        check({tag, "_epc"},   epc_out,              32'd0);
        check({tag, "_cause"}, {30'd0, cause},       32'd0);
        check({tag, "_rd"},    {31'd0, mem_rd},      32'd0);
        check({tag, "_addr"},  mem_addr,             32'd0);
        check({tag, "_busy"},  {31'd0, exc_busy},    32'd0);
    endtask

    task automatic clear_inputs();
        ctrl_pcsource = 2'd0;
        ctrl_pcwrite  = 1'b0;
        exc_opcode    = 1'b0;
        exc_ovf       = 1'b0;
        exc_div0      = 1'b0;
        eret          = 1'b0;
        pc_in         = 32'd0;
        mem_rdata     = 8'd0;
    endtask

    initial begin
        // pcsrc pcw eop eovf ediv eret pcin rdata | mux pw src3 epc cause rd addr busy
        vecs.push_back('{2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00,  2'd2, 1'b1, 32'h0, 32'h0, 2'd0, 1'b0, 32'd0, 1'b0});
        vecs.push_back('{2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h48, 8'h00, 2'd1, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'd0, 1'b0});
        vecs.push_back('{2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00,  2'd0, 1'b0, 32'h44, 32'h44, 2'd2, 1'b1, 32'd254, 1'b1});
        vecs.push_back('{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'hA0,  2'd0, 1'b0, 32'h44, 32'h44, 2'd2, 1'b0, 32'd0, 1'b1});
        vecs.push_back('{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00,  2'd3, 1'b1, 32'hA0, 32'h44, 2'd2, 1'b0, 32'd0, 1'b1});
        vecs.push_back('{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00,  2'd0, 1'b0, 32'h44, 32'h44, 2'd2, 1'b0, 32'd0, 1'b0});
        vecs.push_back('{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00,  2'd3, 1'b1, 32'h44, 32'h44, 2'd2, 1'b0, 32'd0, 1'b1});
        vecs.push_back('{2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 8'h00, 2'd1, 1'b0, 32'h44, 32'h44, 2'd0, 1'b0, 32'd0, 1'b0});
        vecs.push_back('{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h00,  2'd0, 1'b0, 32'hFC, 32'hFC, 2'd1, 1'b1, 32'd253, 1'b1});
        vecs.push_back('{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h10,  2'd0, 1'b0, 32'hFC, 32'hFC, 2'd1, 1'b0, 32'd0, 1'b1});
        vecs.push_back('{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00,  2'd3, 1'b1, 32'h10, 32'hFC, 2'd1, 1'b0, 32'd0, 1'b1});
        vecs.push_back('{2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 8'h00,  2'd0, 1'b0, 32'hFC, 32'hFC, 2'd1, 1'b0, 32'd0, 1'b0});
        vecs.push_back('{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00,  2'd0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 2'd3, 1'b1, 32'd255, 1'b1});
        vecs.push_back('{2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h55,  2'd0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 2'd3, 1'b0, 32'd0, 1'b1});
        vecs.push_back('{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00,  2'd3, 1'b1, 32'h55, 32'hFFFF_FFFC, 2'd3, 1'b0, 32'd0, 1'b1});
        vecs.push_back('{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00,  2'd0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 2'd3, 1'b0, 32'd0, 1'b0});

        // Reset state, with passthrough inputs driven high.
        rst_n = 1'b0;
        clear_inputs();
        ctrl_pcsource = 2'd2;
        ctrl_pcwrite  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();

        // Table-driven sequence: overflow entry, eret, simultaneous events,
        // wrap-around EPC, ignored events outside IDLE.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ctrl_pcsource = vecs[i].pcsrc;
            ctrl_pcwrite  = vecs[i].pcw;
            exc_opcode    = vecs[i].eop;
            exc_ovf       = vecs[i].eovf;
            exc_div0      = vecs[i].ediv;
            eret          = vecs[i].eret;
            pc_in         = vecs[i].pcin;
            mem_rdata     = vecs[i].rdata;
            #1;
            check($sformatf("v%0d_mux", i),   {30'd0, muxpcsource}, {30'd0, vecs[i].x_mux});
            check($sformatf("v%0d_pw", i),    {31'd0, pc_write},    {31'd0, vecs[i].x_pw});
            check($sformatf("v%0d_src3", i),  pc_src3,              vecs[i].x_src3);
            check($sformatf("v%0d_epc", i),   epc_out,              vecs[i].x_epc);
            check($sformatf("v%0d_cause", i), {30'd0, cause},       {30'd0, vecs[i].x_cause});
            check($sformatf("v%0d_rd", i),    {31'd0, mem_rd},      {31'd0, vecs[i].x_rd});
            check($sformatf("v%0d_addr", i),  mem_addr,             vecs[i].x_addr);
            check($sformatf("v%0d_busy", i),  {31'd0, exc_busy},    {31'd0, vecs[i].x_busy});
        end

        // Reset asserted mid-WAIT aborts the entry with no PC write.
        @(negedge clk);
        clear_inputs();
        exc_ovf = 1'b1;
        pc_in   = 32'h200;
        @(negedge clk);
        clear_inputs();
        #1;
        check("mr_memrd_rd", {31'd0, mem_rd}, 32'd1);
        @(negedge clk);
        ctrl_pcsource = 2'd2;
        ctrl_pcwrite  = 1'b1;
        mem_rdata     = 8'h77;
        #1;
        check("mr_wait_busy", {31'd0, exc_busy}, 32'd1);
        check("mr_wait_epc", epc_out, 32'h1FC);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mr_async");
        @(negedge clk);
        #1;
        check_all_zero("mr_held");
        rst_n = 1'b1;
        clear_inputs();
        #1;
        check("mr_rel_cause", {30'd0, cause}, 32'd0);
        check("mr_rel_busy", {31'd0, exc_busy}, 32'd0);
        check("mr_rel_epc", epc_out, 32'd0);
        @(negedge clk);
        #1;
        check("mr_after_pw", {31'd0, pc_write}, 32'd0);
        check("mr_after_mux", {30'd0, muxpcsource}, 32'd0);
        check("mr_after_busy", {31'd0, exc_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
